// File: rtl/key_debounce_bank.sv
// Bank of N_KEYS active-low push-button channels. Each channel is synchronised and debounced,
// then decoded into registered single-cycle press / release / long-press / auto-repeat pulses.
module key_debounce_bank #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_KEYS-1:0] button,
    output logic [N_KEYS-1:0] button_on,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    logic [N_KEYS-1:0] syncMeta_q;
    logic [N_KEYS-1:0] sync_q;
    logic [N_KEYS-1:0] buttonOn_q,     buttonOn_d;
    logic [N_KEYS-1:0] pressPulse_q,   pressPulse_d;
    logic [N_KEYS-1:0] releasePulse_q, releasePulse_d;
    logic [N_KEYS-1:0] longPulse_q,    longPulse_d;
    logic [N_KEYS-1:0] repeatPulse_q,  repeatPulse_d;
    logic [DEB_W-1:0]  debCnt_q  [N_KEYS];
    logic [DEB_W-1:0]  debCnt_d  [N_KEYS];
    logic [HOLD_W-1:0] holdCnt_q [N_KEYS];
    logic [HOLD_W-1:0] holdCnt_d [N_KEYS];
    state_t            state_q   [N_KEYS];
    state_t            state_d   [N_KEYS];

    logic [N_KEYS-1:0] acceptEvt;
    logic [N_KEYS-1:0] pressEvt;
    logic [N_KEYS-1:0] releaseEvt;

    // Sync flops reset to 1 so a button held through reset cannot look like a press mid-reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            syncMeta_q     <= '1;
            sync_q         <= '1;
            buttonOn_q     <= '1;
            pressPulse_q   <= '0;
            releasePulse_q <= '0;
            longPulse_q    <= '0;
            repeatPulse_q  <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                debCnt_q[i]  <= '0;
                holdCnt_q[i] <= '0;
                state_q[i]   <= IDLE;
            end
        end else begin
            syncMeta_q     <= button;
            sync_q         <= syncMeta_q;
            buttonOn_q     <= buttonOn_d;
            pressPulse_q   <= pressPulse_d;
            releasePulse_q <= releasePulse_d;
            longPulse_q    <= longPulse_d;
            repeatPulse_q  <= repeatPulse_d;
            for (int i = 0; i < N_KEYS; i++) begin
                debCnt_q[i]  <= debCnt_d[i];
                holdCnt_q[i] <= holdCnt_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    always_comb begin
        acceptEvt      = '0;
        pressEvt       = '0;
        releaseEvt     = '0;
        buttonOn_d     = buttonOn_q;
        pressPulse_d   = '0;
        releasePulse_d = '0;
        longPulse_d    = '0;
        repeatPulse_d  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            debCnt_d[i]  = debCnt_q[i];
            holdCnt_d[i] = holdCnt_q[i];
            state_d[i]   = state_q[i];
        end

        for (int i = 0; i < N_KEYS; i++) begin
            // Any sample agreeing with the accepted level restarts the stability count.
            if (sync_q[i] == buttonOn_q[i]) begin
                debCnt_d[i] = '0;
            end else if (debCnt_q[i] == DEB_LAST) begin
                debCnt_d[i]   = '0;
                acceptEvt[i]  = 1'b1;
                buttonOn_d[i] = sync_q[i];
            end else begin
                debCnt_d[i] = debCnt_q[i] + DEB_ONE;
            end

            pressEvt[i]       = acceptEvt[i] & ~sync_q[i];
            releaseEvt[i]     = acceptEvt[i] & sync_q[i];
            pressPulse_d[i]   = pressEvt[i];
            releasePulse_d[i] = releaseEvt[i];

            // Release is tested first so it pre-empts a long/repeat terminal count in the same cycle.
            case (state_q[i])
                IDLE: begin
                    if (pressEvt[i]) begin
                        state_d[i]   = PRESSED;
                        holdCnt_d[i] = '0;
                    end
                end
                PRESSED: begin
                    if (releaseEvt[i]) begin
                        state_d[i]   = IDLE;
                        holdCnt_d[i] = '0;
                    end else if (holdCnt_q[i] == LONG_LAST) begin
                        state_d[i]     = HELD;
                        holdCnt_d[i]   = '0;
                        longPulse_d[i] = 1'b1;
                    end else begin
                        holdCnt_d[i] = holdCnt_q[i] + HOLD_ONE;
                    end
                end
                HELD: begin
                    if (releaseEvt[i]) begin
                        state_d[i]   = IDLE;
                        holdCnt_d[i] = '0;
                    end else if (REPEAT_EN != 0) begin
                        if (holdCnt_q[i] == REP_LAST) begin
                            holdCnt_d[i]     = '0;
                            repeatPulse_d[i] = 1'b1;
                        end else begin
                            holdCnt_d[i] = holdCnt_q[i] + HOLD_ONE;
                        end
                    end else begin
                        holdCnt_d[i] = '0;
                    end
                end
                default: begin
                    state_d[i]   = IDLE;
                    holdCnt_d[i] = '0;
                end
            endcase
        end
    end

    assign button_on     = buttonOn_q;
    assign press_pulse   = pressPulse_q;
    assign release_pulse = releasePulse_q;
    assign long_pulse    = longPulse_q;
    assign repeat_pulse  = repeatPulse_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Bench for key_debounce_bank: two instances (auto-repeat on and off) driven by directed and random
// button activity, compared every cycle against a window/elapsed-time reference model via scoreboard queues.
module tb_key_debounce_bank;

    localparam int NK   = 4;
    localparam int DEB  = 8;
    localparam int LONG = 32;
    localparam int REP  = 8;

    logic          clock  = 1'b0;
    logic          reset  = 1'b1;
    logic [NK-1:0] button = '1;

    logic [NK-1:0] onA, pressA, releaseA, longA, repeatA;
    logic [NK-1:0] onB, pressB, releaseB, longB, repeatB;

    int checks = 0;
    int passes = 0;

    logic [19:0] expQA [$];
    logic [19:0] expQB [$];

    always #5 clock = ~clock;

    key_debounce_bank #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1)
    ) dutA (
        .clock(clock), .reset(reset), .button(button),
        .button_on(onA), .press_pulse(pressA), .release_pulse(releaseA),
        .long_pulse(longA), .repeat_pulse(repeatA)
    );

    key_debounce_bank #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(0)
    ) dutB (
        .clock(clock), .reset(reset), .button(button),
        .button_on(onB), .press_pulse(pressB), .release_pulse(releaseB),
        .long_pulse(longB), .repeat_pulse(repeatB)
    );

    // Reference model: the pin reaches the debouncer two edges late; a level is accepted once the
    // last DEB delayed samples all disagree with it; hold events follow from edges elapsed since the press.
    logic [NK-1:0] pinDly1, pinDly2, seen, level;
    logic [NK-1:0] mPress, mRelease, mLong, mRepeat;
    logic [NK-1:0] window [$];
    bit            held      [NK];
    int            pressEdge [NK];
    int            edgeNo = 0;
    int            elapsed;
    bit            allDiff;

    always @(posedge clock) begin
        edgeNo++;
        mPress = '0; mRelease = '0; mLong = '0; mRepeat = '0;
        if (reset) begin
            pinDly1 = '1;
            pinDly2 = '1;
            level   = '1;
            window.delete();
            for (int c = 0; c < NK; c++) held[c] = 1'b0;
        end else begin
            seen    = pinDly2;
            pinDly2 = pinDly1;
            pinDly1 = button;
            window.push_back(seen);
            if (window.size() > DEB) void'(window.pop_front());
            for (int c = 0; c < NK; c++) begin
                allDiff = (window.size() == DEB);
                for (int k = 0; k < window.size(); k++)
                    if (window[k][c] == level[c]) allDiff = 1'b0;
                if (allDiff) begin
                    level[c] = ~level[c];
                    if (level[c] == 1'b0) begin
                        mPress[c]    = 1'b1;
                        held[c]      = 1'b1;
                        pressEdge[c] = edgeNo;
                    end else begin
                        mRelease[c] = 1'b1;
                        held[c]     = 1'b0;
                    end
                end else if (held[c]) begin
                    elapsed = edgeNo - pressEdge[c];
                    if (elapsed == LONG)
                        mLong[c] = 1'b1;
                    else if (elapsed > LONG && ((elapsed - LONG) % REP) == 0)
                        mRepeat[c] = 1'b1;
                end
            end
        end
        expQA.push_back({level, mPress, mRelease, mLong, mRepeat});
        expQB.push_back({level, mPress, mRelease, mLong, 4'b0000});
    end

    task automatic checkOutput(input string name, input logic [19:0] got, input logic [19:0] want);
        checks++;
        if (got === want)
            passes++;
        else
            $display("[TB] FAIL %s edge %0d: got on/pr/rl/lg/rp=%h required %h", name, edgeNo, got, want);
    endtask

    // Monitor: every edge is an output presentation, so pop and compare one entry per cycle.
    always @(negedge clock) begin
        if (expQA.size() != 0) checkOutput("dutA", {onA, pressA, releaseA, longA, repeatA}, expQA.pop_front());
        if (expQB.size() != 0) checkOutput("dutB", {onB, pressB, releaseB, longB, repeatB}, expQB.pop_front());
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus();
        int dur [NK];
        reset  = 1'b1;
        button = '1;
        waitCycles(3);
        reset = 1'b0;
        waitCycles(50);

        $display("[TB] single press on key 0");
        button[0] = 1'b0; waitCycles(20);
        button[0] = 1'b1; waitCycles(20);

        $display("[TB] bouncing key 1 then settle low");
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) button[1] = ~button[1];
            waitCycles(1);
        end
        button[1] = 1'b0; waitCycles(20);
        button[1] = 1'b1; waitCycles(20);

        $display("[TB] long hold on key 2");
        button[2] = 1'b0; waitCycles(80);
        button[2] = 1'b1; waitCycles(30);

        $display("[TB] release landing on long terminal count, key 0");
        button[0] = 1'b0; waitCycles(31);
        button[0] = 1'b1; waitCycles(30);

        $display("[TB] reset while key 3 held");
        button[3] = 1'b0; waitCycles(55);
        reset = 1'b1; waitCycles(3);
        reset = 1'b0; waitCycles(30);
        button[3] = 1'b1; waitCycles(30);

        $display("[TB] random activity");
        for (int c = 0; c < NK; c++) dur[c] = $urandom_range(1, 20);
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < NK; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    button[c] = ~button[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 75);
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            waitCycles(1);
        end
        reset  = 1'b0;
        button = '1;
        waitCycles(30);
    endtask

    initial begin
        applyStimulus();
        waitCycles(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
